// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine: a 128-bit block is substituted
// LANES bytes per cycle in place, then held on a valid/ready output port.

module sub_bytes_lane (
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  logic [7:0] fwd_inv;
  logic [7:0] fwd_byte;
  logic [7:0] inv_aff;
  logic [7:0] inv_byte;

  assign fwd_inv  = gf_inv(in_byte);
  assign fwd_byte = fwd_inv ^ {fwd_inv[6:0], fwd_inv[7]} ^ {fwd_inv[5:0], fwd_inv[7:6]}
                  ^ {fwd_inv[4:0], fwd_inv[7:5]} ^ {fwd_inv[3:0], fwd_inv[7:4]} ^ 8'h63;
  assign inv_aff  = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                  ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
  assign inv_byte = gf_inv(inv_aff);
  assign out_byte = inv ? inv_byte : fwd_byte;
endmodule

module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [127:0]    work_sub;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_in[gi] = work_q[(int'(cnt_q) * LANES + gi) * 8 +: 8];
      sub_bytes_lane u_lane (
        .in_byte  (lane_in[gi]),
        .inv      (inv_q),
        .out_byte (lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    work_sub = work_q;
    for (int i = 0; i < LANES; i++) begin
      work_sub[(int'(cnt_q) * LANES + i) * 8 +: 8] = lane_out[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = work_sub;
        if (cnt_q == CW'(NCYC - 1)) begin
          cnt_d   = '0;
          out_d   = work_sub;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_state;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_state = out_q;
  assign busy      = (state_q == BUSY);
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed and random checks of sub_bytes_engine against hand vectors and an
// independently generated S-box table.

module tb_sub_bytes_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  logic         sw_in_valid, sw_out_ready;
  logic [4:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_out_state [5];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] V0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E0 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sweep
      sub_bytes_engine #(.LANES(1 << gi)) u_sw (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[gi]),
        .in_state(V0), .in_inv(1'b0), .out_valid(sw_out_valid[gi]),
        .out_ready(sw_out_ready), .out_state(sw_out_state[gi]), .busy(sw_busy[gi])
      );
    end
  endgenerate

  typedef struct {
    string        name;
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Classic generator walk: p steps through all nonzero elements by *3, q tracks 1/p.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tbl[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = inv ? inv_tbl[d[8*b +: 8]] : fwd_tbl[d[8*b +: 8]];
    return r;
  endfunction

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; in_state = din; in_inv = inv; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_state = ~din; in_inv = ~inv;
    wait_out(cyc);
    check({name, "_lat"}, 128'(cyc), 128'd5);
    check({name, "_data"}, out_state, exp);
  endtask

  initial begin
    int cyc;
    int lat [5];
    logic [127:0] exp_q [$];
    logic [127:0] d;
    logic         iv, pending;
    int sent, recv, budget;

    build_tables();
    vecs[0] = '{"fwd_fips", V0, 1'b0, E0};
    vecs[1] = '{"inv_fips", E0, 1'b1, V0};
    vecs[2] = '{"inv_zero", 128'h0, 1'b1, {16{8'h52}}};
    vecs[3] = '{"fwd_zero", 128'h0, 1'b0, {16{8'h63}}};
    vecs[4] = '{"fwd_ones", {16{8'hff}}, 1'b0, {16{8'h16}}};
    vecs[5] = '{"inv_ones", {16{8'hff}}, 1'b1, {16{8'h7d}}};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_state", out_state, 128'h0);

    foreach (vecs[i]) run_block(vecs[i].name, vecs[i].din, vecs[i].inv, vecs[i].exp);

    // Lane sweep: all widths start together, each latency recorded independently.
    @(negedge clk);
    sw_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_in_valid = 1'b0;
    foreach (lat[i]) lat[i] = 0;
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < 5; i++) if (sw_out_valid[i] && lat[i] == 0) lat[i] = c;
      if (c < 20) @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sweep_lat_L%0d", 1 << i), 128'(lat[i]), 128'(16 / (1 << i) + 1));
      check($sformatf("sweep_data_L%0d", 1 << i), sw_out_state[i], E0);
    end

    // Backpressure: result held, upstream request ignored until out_ready rises.
    @(negedge clk);
    in_valid = 1'b1; in_state = V0; in_inv = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    check("bp_lat", 128'(cyc), 128'd5);
    in_valid = 1'b1; in_state = E0; in_inv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_state}, {1'b1, 1'b0, E0});
    end
    out_ready = 1'b1;
    #1;
    check("bp_b2b_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_state = '0; in_inv = 1'b0;
    check("bp_b2b_state", {out_valid, busy}, {1'b0, 1'b1});
    wait_out(cyc);
    check("bp_b2b_lat", 128'(cyc), 128'd5);
    check("bp_b2b_data", out_state, V0);

    // Reset while chunk 2 is being substituted.
    @(negedge clk);
    in_valid = 1'b1; in_state = E0; in_inv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", {out_valid, busy, in_ready, out_state}, {1'b0, 1'b0, 1'b1, 128'h0});
    run_block("post_rst", V0, 1'b0, E0);

    // Random regression with stalls on both sides.
    sent = 0; recv = 0; budget = 0; pending = 1'b0;
    while ((sent < 1000 || recv < 1000) && budget < 60000) begin
      @(negedge clk);
      budget++;
      if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        iv = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_valid  = pending;
      in_state  = pending ? d : {$urandom, $urandom, $urandom, $urandom};
      in_inv    = pending ? iv : 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rnd_extra%0d", recv), out_state, 128'hx);
        end else begin
          check($sformatf("rnd_blk%0d", recv), out_state, exp_q.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(d, iv));
        sent++;
        pending = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rnd_sent", 128'(sent), 128'd1000);
    check("rnd_recv", 128'(recv), 128'd1000);
    check("rnd_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Parametrised, iterative AES SubBytes / InvSubBytes engine for the AES datapath. It accepts a 128-bit state over a valid/ready handshake. It substitutes LANES bytes per clock through forward or inverse S-box lanes, then holds the result until the downstream consumer takes it. LANES lets the round logic trade area against latency; the inverse mode serves the decryption rounds.

Parameters:
LANES, 4, number of bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is a elaboration-time error.
NCYC, 16/LANES (derived localparam, not overridable), number of substitution cycles per block.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents a block.
in_ready  output  1  engine can accept a block this cycle.
in_state  input  128  state to substitute; byte i = in_state[8i+7:8i].
in_inv  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled with the block.
out_valid  output  1  out_state holds a finished block.
out_ready  input  1  downstream accepts out_state.
out_state  output  128  substituted state, same byte ordering as in_state.
busy  output  1  high while in BUSY.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. All registers update on the rising edge of clk only.
- Reset: state=IDLE, out_valid=0, busy=0, out_state=0, chunk counter=0, mode register=0.
- in_ready is combinational: 1 in IDLE, or in DONE when out_ready=1 (back-to-back transfer). It is 0 in BUSY.
- FSM states and transitions:
  - IDLE: on in_valid&in_ready, latch in_state into the work register and in_inv into the mode register, clear the counter, go to BUSY.
  - BUSY: each cycle, bytes k*LANES..k*LANES+LANES-1 (k = counter) of the work register are replaced in place by S(byte) or S^-1(byte), selected by the mode register. Counter increments. After chunk k=NCYC-1 the engine goes to DONE.
  - DONE: out_valid=1 and out_state = work register, held stable until out_ready. On out_ready with no new accept, go to IDLE and clear out_valid. On out_ready together with in_valid, accept the new block and go directly to BUSY, with out_valid=0 on the next cycle.
- Latency: the accept edge is cycle 0; out_valid rises at cycle NCYC+1. For LANES=16 that is 2 cycles.
- Throughput: one block per NCYC+1 cycles, given a sustained ready downstream.
- Stability:
  - in_state and in_inv are ignored outside the accept cycle.
  - Changes to in_inv during BUSY have no effect.
  - out_state changes only on entry to DONE or on reset.
- out_ready while not in DONE is ignored. in_valid while in_ready=0 is not accepted; the upstream must hold it.
- S-boxes:
  - Forward: FIPS-197 table, with LANES identical combinational lookup instances.
  - Inverse: FIPS-197 inverse table, same number of instances.
  - No pipeline registers inside a lane.
- Reset mid-operation (BUSY or DONE): the block in flight is dropped. Outputs return to reset values on the next edge, with no partial result visible.
- The counter wraps only through the DONE transition; it never exceeds NCYC-1.

Test Plan:
- LANES=4, forward: in_state=128'h00112233445566778899aabbccddeeff, in_inv=0, out_ready=1 -> out_valid rises exactly 5 cycles after accept; out_state=128'h638293c31bfc33f5c4eeacea4bc12816.
- LANES=4, inverse: in_state=128'h638293c31bfc33f5c4eeacea4bc12816, in_inv=1 -> out_state=128'h00112233445566778899aabbccddeeff. Also all-zero input with in_inv=1 -> every byte 8'h52.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid stays 1, out_state stable, in_ready=0. Raise out_ready together with in_valid -> the new block is accepted that same cycle.
- Sweep LANES=1, 2, 8, 16 with the forward vector -> identical out_state; latency 17, 9, 3 and 2 cycles respectively.
- Assert rst during BUSY at chunk 2 -> next cycle out_valid=0, busy=0, in_ready=1, out_state=0. A following block completes normally.
- Random regression: 1000 random blocks with random in_inv and random out_ready stalls, checked against a reference model -> no lost or duplicated blocks, and each output matches its input and mode.
